// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: credit accumulation, vend, 5-unit change return
// and a multiplexed decimal 7-segment credit display.
`timescale 1ns/1ps
module vending_ctrl #(
  parameter int PRICE      = 15,
  parameter int MAXCREDIT  = 95,
  parameter int DIGITS     = 2,
  parameter int SCAN_DIV   = 4,
  parameter int CHANGE_GAP = 2
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              co5,
  input  logic              co10,
  input  logic              co50,
  input  logic              pay,
  input  logic              cancel,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] ctrl,
  output logic              payok,
  output logic              change,
  output logic              reject,
  output logic              busy
);

  localparam int CW = $clog2(MAXCREDIT + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = $clog2(CHANGE_GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_REFUND} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_credit, w_credit_nxt;
  logic [GW-1:0] r_gap;
  logic [SW-1:0] r_scan;
  logic [DW-1:0] r_digit;
  logic          r_reject, w_reject;
  logic          r_co5_q, r_co10_q, r_co50_q, r_pay_q, r_cancel_q;
  logic          w_e5, w_e10, w_e50, w_pay_ev, w_cancel_ev, w_coin_ok, w_open;
  logic [1:0]    w_ncoin;
  int            w_coinval, w_sum;
  logic [3:0]    w_digit_val;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign w_e5        = co5 & ~r_co5_q;
  assign w_e10       = co10 & ~r_co10_q;
  assign w_e50       = co50 & ~r_co50_q;
  assign w_pay_ev    = pay & ~r_pay_q;
  assign w_cancel_ev = cancel & ~r_cancel_q;
  assign w_ncoin     = {1'b0, w_e5} + {1'b0, w_e10} + {1'b0, w_e50};
  assign w_coinval   = w_e5 ? 5 : (w_e10 ? 10 : (w_e50 ? 50 : 0));
  assign w_sum       = int'(r_credit) + w_coinval;
  assign w_open      = (r_state == S_IDLE) || (r_state == S_COLLECT);
  // A coin is only taken alone: simultaneous coins or a coinciding pay/cancel reject it.
  assign w_coin_ok   = (w_ncoin == 2'd1) && !w_pay_ev && !w_cancel_ev && (w_sum <= MAXCREDIT);

  always_ff @(posedge ck) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_reject   <= 1'b0;
      r_gap      <= '0;
      r_co5_q    <= co5;
      r_co10_q   <= co10;
      r_co50_q   <= co50;
      r_pay_q    <= pay;
      r_cancel_q <= cancel;
    end else begin
      r_state    <= w_next;
      r_credit   <= w_credit_nxt;
      r_reject   <= w_reject;
      r_co5_q    <= co5;
      r_co10_q   <= co10;
      r_co50_q   <= co50;
      r_pay_q    <= pay;
      r_cancel_q <= cancel;
      if (r_state == S_REFUND)
        r_gap <= (r_gap == '0) ? GW'(CHANGE_GAP) : r_gap - 1'b1;
      else
        r_gap <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_credit_nxt = r_credit;
    w_reject     = (w_ncoin != 2'd0) && !(w_open && w_coin_ok);
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_cancel_ev && r_state == S_COLLECT) begin
          w_next = S_REFUND;
        end else if (w_pay_ev && r_state == S_COLLECT && r_credit >= CW'(PRICE)) begin
          w_next = S_VEND;
        end else if (w_coin_ok) begin
          w_credit_nxt = CW'(w_sum);
          w_next       = S_COLLECT;
        end
      end
      S_VEND: begin
        w_credit_nxt = r_credit - CW'(PRICE);
        w_next       = (r_credit == CW'(PRICE)) ? S_IDLE : S_REFUND;
      end
      S_REFUND: begin
        if (r_gap == '0) begin
          w_credit_nxt = (r_credit >= CW'(5)) ? r_credit - CW'(5) : '0;
          w_next       = (r_credit <= CW'(5)) ? S_IDLE : S_REFUND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    payok  = 1'b0;
    busy   = 1'b0;
    change = 1'b0;
    case (r_state)
      S_VEND: begin
        payok = 1'b1;
        busy  = 1'b1;
      end
      S_REFUND: begin
        busy   = 1'b1;
        change = (r_gap == '0);
      end
      default: ;
    endcase
  end

  assign reject = r_reject;

  always_ff @(posedge ck) begin
    if (reset) begin
      r_scan  <= '0;
      r_digit <= '0;
    end else if (r_scan == SW'(SCAN_DIV - 1)) begin
      r_scan  <= '0;
      r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // Display path is purely combinational from credit so seg never lags ctrl.
  always_comb begin
    w_digit_val = 4'd0;
    for (int k = 0; k < DIGITS; k++)
      if (r_digit == DW'(k))
        w_digit_val = 4'((int'(r_credit) / pow10(k)) % 10);
  end

  assign ctrl = DIGITS'(1) << r_digit;
  assign seg  = glyph(w_digit_val);

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl with default parameters; each step checks
// hand-computed outputs using immediate assertions.
`timescale 1ns/1ps
module tb_vending_ctrl;

  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic       co5 = 1'b0, co10 = 1'b0, co50 = 1'b0, pay = 1'b0, cancel = 1'b0;
  logic [6:0] seg;
  logic [1:0] ctrl;
  logic       payok, change, reject, busy;

  int total = 0;
  int bad   = 0;
  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [15:0] pv, cv, bv;
  int cnt, n;

  vending_ctrl #(.PRICE(15), .MAXCREDIT(95), .DIGITS(2), .SCAN_DIV(4), .CHANGE_GAP(2)) dut (
    .ck(ck), .reset(reset), .co5(co5), .co10(co10), .co50(co50), .pay(pay),
    .cancel(cancel), .seg(seg), .ctrl(ctrl), .payok(payok), .change(change),
    .reject(reject), .busy(busy)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic coin(input int v, input logic exp_rej, input string tag);
    case (v)
      5:       co5 = 1'b1;
      10:      co10 = 1'b1;
      default: co50 = 1'b1;
    endcase
    tick();
    chk({tag, "_rej"}, reject, exp_rej);
    co5 = 1'b0; co10 = 1'b0; co50 = 1'b0;
    tick();
    chk({tag, "_rej_clr"}, reject, 1'b0);
  endtask

  task automatic show(input int value, input string tag);
    int k;
    k = 0;
    while (ctrl !== 2'b01 && k < 20) begin tick(); k++; end
    chk({tag, "_uctl"}, ctrl, 2'b01);
    chk({tag, "_useg"}, seg, glyph_tab[value % 10]);
    k = 0;
    while (ctrl !== 2'b10 && k < 20) begin tick(); k++; end
    chk({tag, "_tctl"}, ctrl, 2'b10);
    chk({tag, "_tseg"}, seg, glyph_tab[value / 10]);
  endtask

  task automatic capture(input int len, output logic [15:0] p, output logic [15:0] c,
                         output logic [15:0] b);
    p = '0; c = '0; b = '0;
    for (int i = 0; i < len; i++) begin
      p[i] = payok; c[i] = change; b[i] = busy;
      tick();
    end
  endtask

  initial begin
    // reset with co5 held high: no event may result afterwards
    co5 = 1'b1;
    tick(); tick();
    chk("rst_payok", payok, 1'b0);
    chk("rst_change", change, 1'b0);
    chk("rst_reject", reject, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctrl", ctrl, 2'b01);
    chk("rst_seg", seg, 7'h3F);
    reset = 1'b0;
    tick();
    chk("hold_rej", reject, 1'b0);
    co5 = 1'b0;
    tick();
    show(0, "hold");

    // 5+10+10 = 25, buy: vend then two change pulses three cycles apart
    coin(5, 1'b0, "a5"); coin(10, 1'b0, "a10"); coin(10, 1'b0, "b10");
    show(25, "d25");
    pay = 1'b1; tick(); pay = 1'b0;
    capture(16, pv, cv, bv);
    chk("buy25_payok", pv, 16'h0001);
    chk("buy25_change", cv, 16'h0012);
    chk("buy25_busy", bv, 16'h001F);
    show(0, "after25");

    // credit 10: pay ignored, cancel refunds two coins
    coin(10, 1'b0, "c10");
    pay = 1'b1; tick(); pay = 1'b0;
    chk("low_payok", payok, 1'b0);
    chk("low_busy", busy, 1'b0);
    tick();
    show(10, "d10");
    cancel = 1'b1; tick(); cancel = 1'b0;
    capture(16, pv, cv, bv);
    chk("can10_payok", pv, 16'h0000);
    chk("can10_change", cv, 16'h0009);
    chk("can10_busy", bv, 16'h000F);
    show(0, "after10");

    // credit ceiling
    coin(50, 1'b0, "m50"); coin(10, 1'b0, "m10a"); coin(10, 1'b0, "m10b");
    coin(10, 1'b0, "m10c"); coin(10, 1'b0, "m10d");
    show(90, "d90");
    coin(10, 1'b1, "over10");
    show(90, "still90");
    coin(5, 1'b0, "top5");
    show(95, "d95");
    coin(50, 1'b1, "over50");
    show(95, "still95");
    reset = 1'b1; tick(); reset = 1'b0;
    show(0, "clr95");

    // exact price: vend straight back to idle, no change
    coin(5, 1'b0, "e5"); coin(10, 1'b0, "e10");
    pay = 1'b1; tick(); pay = 1'b0;
    capture(8, pv, cv, bv);
    chk("exact_payok", pv, 16'h0001);
    chk("exact_change", cv, 16'h0000);
    chk("exact_busy", bv, 16'h0001);

    // pay and cancel together at credit 20: cancel wins, four pulses
    coin(10, 1'b0, "p10a"); coin(10, 1'b0, "p10b");
    pay = 1'b1; cancel = 1'b1; tick(); pay = 1'b0; cancel = 1'b0;
    capture(16, pv, cv, bv);
    chk("pc_payok", pv, 16'h0000);
    chk("pc_change", cv, 16'h0249);
    chk("pc_busy", bv, 16'h03FF);

    // coin coinciding with pay at credit 15: coin rejected, vend happens
    coin(5, 1'b0, "q5"); coin(10, 1'b0, "q10");
    co5 = 1'b1; pay = 1'b1; tick(); co5 = 1'b0; pay = 1'b0;
    chk("cp_payok", payok, 1'b1);
    chk("cp_reject", reject, 1'b1);
    tick();
    chk("cp_busy", busy, 1'b0);
    show(0, "cp");

    // simultaneous coins rejected once
    co5 = 1'b1; co10 = 1'b1; tick();
    chk("dual_rej", reject, 1'b1);
    chk("dual_busy", busy, 1'b0);
    co5 = 1'b0; co10 = 1'b0; tick();
    chk("dual_rej_clr", reject, 1'b0);
    show(0, "dual");

    // coin during refund rejected, pulse count unchanged
    coin(10, 1'b0, "r10a"); coin(10, 1'b0, "r10b");
    cancel = 1'b1; tick(); cancel = 1'b0;
    cnt = int'(change);
    co5 = 1'b1; tick(); co5 = 1'b0;
    chk("ref_coin_rej", reject, 1'b1);
    cnt += int'(change);
    for (int i = 0; i < 15; i++) begin tick(); cnt += int'(change); end
    chk("ref_pulses", cnt, 4);
    show(0, "ref");

    // reset aborts a refund of 45 after the third pulse
    coin(10, 1'b0, "s10a"); coin(10, 1'b0, "s10b"); coin(10, 1'b0, "s10c");
    coin(10, 1'b0, "s10d"); coin(5, 1'b0, "s5");
    show(45, "d45");
    cancel = 1'b1; tick(); cancel = 1'b0;
    cnt = 0; n = 0;
    while (n < 40) begin
      if (change) cnt++;
      if (cnt == 3) break;
      tick(); n++;
    end
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_ctrl", ctrl, 2'b01);
    chk("abort_seg", seg, 7'h3F);
    chk("abort_busy", busy, 1'b0);
    chk("abort_change", change, 1'b0);
    for (int i = 0; i < 30; i++) begin tick(); cnt += int'(change); end
    chk("abort_pulses", cnt, 3);
    show(0, "abort");

    // scan timing with credit 25
    coin(5, 1'b0, "t5"); coin(10, 1'b0, "t10a"); coin(10, 1'b0, "t10b");
    n = 0;
    while (ctrl !== 2'b10 && n < 20) begin tick(); n++; end
    while (ctrl !== 2'b01 && n < 40) begin tick(); n++; end
    for (int i = 0; i < 16; i++) begin
      chk("scan_ctrl", ctrl, ((i / 4) % 2) ? 2'b10 : 2'b01);
      chk("scan_seg", seg, ((i / 4) % 2) ? 7'h5B : 7'h6D);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
